// File: rtl/inst_encoder.sv
// Packs opcode/register/funct fields and a sign-extended immediate into an RV32I word; 2-cycle latency.
// Illegal requests become a flagged NOP. The input stalls only when both stages hold words and out_ready is low.
module inst_encoder #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_inst,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_err,
  output logic                  err_sticky
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  logic                  s1_valid_q;
  logic [6:0]            s1_op_q;
  logic [4:0]            s1_rd_q;
  logic [4:0]            s1_rs1_q;
  logic [4:0]            s1_rs2_q;
  logic [2:0]            s1_f3_q;
  logic [6:0]            s1_f7_q;
  logic [20:0]           s1_imm_q;
  logic                  s1_err_q;
  logic                  s1_err_d;

  logic                  out_valid_q;
  logic [31:0]           out_inst_q;
  logic [31:0]           out_inst_d;
  logic                  out_err_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic                  err_sticky_q;

  logic s2_adv;
  logic in_fire;
  logic out_fire;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = (!s1_valid_q || s2_adv) && !clear;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready && !clear;

  assign out_valid  = out_valid_q;
  assign out_inst   = out_inst_q;
  assign out_addr   = out_addr_q;
  assign out_err    = out_err_q;
  assign err_sticky = err_sticky_q;

  // Range checks: the immediate must survive truncation to the field and re-sign-extension.
  always_comb begin
    logic fits12, fits13, fits21, is_shift;
    fits12   = (in_imm[31:11] == {21{in_imm[11]}});
    fits13   = (in_imm[31:12] == {20{in_imm[12]}});
    fits21   = (in_imm[31:20] == {12{in_imm[20]}});
    is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    s1_err_d = 1'b1;
    case (in_opcode)
      OP_R:                       s1_err_d = 1'b0;
      OP_IMM:                     s1_err_d = is_shift ? (in_imm[31:5] != '0) : !fits12;
      OP_LOAD, OP_JALR, OP_STORE: s1_err_d = !fits12;
      OP_BRANCH:                  s1_err_d = !fits13 || in_imm[0];
      OP_JAL:                     s1_err_d = !fits21 || in_imm[0];
      OP_SYS:                     s1_err_d = 1'b0;
      default:                    s1_err_d = 1'b1;
    endcase
  end

  always_comb begin
    out_inst_d = NOP_WORD;
    case (s1_op_q)
      OP_R:
        out_inst_d = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      OP_IMM:
        if (s1_f3_q == 3'b001 || s1_f3_q == 3'b101)
          out_inst_d = {s1_f7_q, s1_imm_q[4:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
        else
          out_inst_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      OP_LOAD, OP_JALR:
        out_inst_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      OP_STORE:
        out_inst_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], s1_op_q};
      OP_BRANCH:
        out_inst_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                      s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      OP_JAL:
        out_inst_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                      s1_rd_q, s1_op_q};
      OP_SYS:
        out_inst_d = ECALL_WORD;
      default:
        out_inst_d = NOP_WORD;
    endcase
    if (s1_err_q) out_inst_d = NOP_WORD;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_rd_q    <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_f3_q    <= '0;
      s1_f7_q    <= '0;
      s1_imm_q   <= '0;
      s1_err_q   <= 1'b0;
    end else if (clear) begin
      s1_valid_q <= 1'b0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_op_q    <= in_opcode;
      s1_rd_q    <= in_rd;
      s1_rs1_q   <= in_rs1;
      s1_rs2_q   <= in_rs2;
      s1_f3_q    <= in_funct3;
      s1_f7_q    <= in_funct7;
      s1_imm_q   <= in_imm[20:0];
      s1_err_q   <= s1_err_d;
    end else if (s2_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Output word only reloads when a new one arrives, so it holds through backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_inst_q   <= '0;
      out_err_q    <= 1'b0;
      out_addr_q   <= BASE;
      err_sticky_q <= 1'b0;
    end else if (clear) begin
      out_valid_q  <= 1'b0;
      out_addr_q   <= BASE;
      err_sticky_q <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_inst_q <= out_inst_d;
          out_err_q  <= s1_err_q;
        end
      end
      if (out_fire) begin
        out_addr_q <= out_addr_q + ADDR_WIDTH'(1);
        if (out_err_q) err_sticky_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed-vector bench for inst_encoder: a wide-address instance plus a 2-bit-address instance
// (BASE_ADDR=1) sharing stimulus, so address wrap and base reload are visible.
module tb_inst_encoder;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        in_valid;
  logic        out_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;

  logic        in_ready, out_valid, out_err, err_sticky;
  logic [31:0] out_inst;
  logic [9:0]  out_addr;
  logic        in_ready2, out_valid2, out_err2, err_sticky2;
  logic [31:0] out_inst2;
  logic [1:0]  out_addr2;

  inst_encoder u_dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky)
  );

  inst_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2),
    .out_addr(out_addr2), .out_err(out_err2), .err_sticky(err_sticky2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] inst2;
    logic [9:0]  addr;
    logic [1:0]  addr2;
    logic        err;
    int          cyc;
  } rec_t;

  rec_t q[$];
  int   cyc;
  int   n_chk;
  int   n_err;
  int   n_acc;
  vec_t tbl[12];
  vec_t bp[4];

  always @(posedge clk) cyc <= cyc + 1;

  // Output transfers are recorded mid-cycle; inputs only change just after the rising edge.
  always @(negedge clk)
    if (reset_n && !clear && out_valid && out_ready)
      q.push_back('{out_inst, out_inst2, out_addr, out_addr2, out_err, cyc});

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v);
    bit acc;
    int n;
    in_valid  = 1'b1;
    in_opcode = v.op;  in_rd = v.rd;   in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3;  in_funct7 = v.f7; in_imm = v.imm;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (acc) n_acc++;
    else check_eq("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic expect_word(input int idx, input logic [31:0] inst, input logic [9:0] addr,
                             input logic err);
    if (idx < q.size()) begin
      check_eq($sformatf("inst[%0d]", idx), q[idx].inst, inst);
      check_eq($sformatf("inst2[%0d]", idx), q[idx].inst2, inst);
      check_eq($sformatf("addr[%0d]", idx), 32'(q[idx].addr), 32'(addr));
      check_eq($sformatf("addr2[%0d]", idx), 32'(q[idx].addr2), 32'((addr + 10'd1) & 10'd3));
      check_eq($sformatf("err[%0d]", idx), 32'(q[idx].err), 32'(err));
    end else begin
      check_eq($sformatf("missing_word[%0d]", idx), 32'(q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    //          op          rd     rs1    rs2    f3    f7            imm           expected      err
    tbl[0]  = '{7'b0100011, 5'd0,  5'd2,  5'd5,  3'd2, 7'd0,         32'd8,        32'h00512423, 1'b0};
    tbl[1]  = '{7'b1100011, 5'd0,  5'd0,  5'd0,  3'd0, 7'd0,         32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
    tbl[2]  = '{7'b1101111, 5'd1,  5'd0,  5'd0,  3'd0, 7'd0,         32'h00000800, 32'h001000EF, 1'b0};
    tbl[3]  = '{7'b1101111, 5'd1,  5'd0,  5'd0,  3'd0, 7'd0,         32'd3,        32'h00000013, 1'b1};
    tbl[4]  = '{7'b0010011, 5'd1,  5'd2,  5'd0,  3'd0, 7'd0,         32'd2048,     32'h00000013, 1'b1};
    tbl[5]  = '{7'b0000000, 5'd1,  5'd2,  5'd3,  3'd0, 7'd0,         32'd0,        32'h00000013, 1'b1};
    tbl[6]  = '{7'b0010011, 5'd3,  5'd3,  5'd0,  3'd1, 7'd0,         32'd31,       32'h01F19193, 1'b0};
    tbl[7]  = '{7'b0010011, 5'd1,  5'd2,  5'd0,  3'd0, 7'd0,         32'd2047,     32'h7FF10093, 1'b0};
    tbl[8]  = '{7'b0010011, 5'd1,  5'd2,  5'd0,  3'd0, 7'd0,         32'hFFFFF800, 32'h80010093, 1'b0};
    tbl[9]  = '{7'b1100011, 5'd0,  5'd1,  5'd2,  3'd0, 7'd0,         32'd4096,     32'h00000013, 1'b1};
    tbl[10] = '{7'b1110011, 5'd5,  5'd7,  5'd9,  3'd3, 7'h55,        32'h123,      32'h00000073, 1'b0};
    tbl[11] = '{7'b0010011, 5'd3,  5'd3,  5'd0,  3'd1, 7'd0,         32'd32,       32'h00000013, 1'b1};
    bp[0]   = '{7'b0110011, 5'd3,  5'd1,  5'd2,  3'd0, 7'd0,         32'h12345678, 32'h002081B3, 1'b0};
    bp[1]   = '{7'b0110011, 5'd3,  5'd1,  5'd2,  3'd0, 7'b0100000,   32'd0,        32'h402081B3, 1'b0};
    bp[2]   = '{7'b0000011, 5'd4,  5'd1,  5'd0,  3'd2, 7'd0,         32'd4,        32'h0040A203, 1'b0};
    bp[3]   = '{7'b1100111, 5'd0,  5'd1,  5'd0,  3'd0, 7'd0,         32'd0,        32'h00008067, 1'b0};

    n_chk = 0; n_err = 0; n_acc = 0; cyc = 0;
    reset_n = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    #2 reset_n = 1'b0;
    tick(2);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_inst", out_inst, 32'd0);
    check_eq("rst_err", 32'(out_err), 32'd0);
    check_eq("rst_sticky", 32'(err_sticky), 32'd0);
    check_eq("rst_addr", 32'(out_addr), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst2_addr", 32'(out_addr2), 32'd1);
    check_eq("rst2_valid", 32'(out_valid2), 32'd0);
    check_eq("rst2_inst", out_inst2, 32'd0);
    check_eq("rst2_err", 32'(out_err2), 32'd0);
    check_eq("rst2_sticky", 32'(err_sticky2), 32'd0);
    check_eq("rst2_in_ready", 32'(in_ready2), 32'd1);
    reset_n = 1'b1;
    tick(1);

    // addi x1,x2,-1: word appears two edges after acceptance
    send('{7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'h0, 1'b0});
    check_eq("lat_one_edge_valid", 32'(out_valid), 32'd0);
    tick(1);
    check_eq("lat_two_edge_valid", 32'(out_valid), 32'd1);
    check_eq("addi_inst", out_inst, 32'hFFF10093);
    check_eq("addi_addr", 32'(out_addr), 32'd0);
    check_eq("addi_err", 32'(out_err), 32'd0);
    tick(3);
    check_eq("addr_after_one", 32'(out_addr), 32'd1);
    do_clear();
    check_eq("clear_addr", 32'(out_addr), 32'd0);
    check_eq("clear_addr2", 32'(out_addr2), 32'd1);

    // back-to-back encoding table
    q.delete();
    for (int i = 0; i < 12; i++) send(tbl[i]);
    tick(4);
    check_eq("tbl_count", 32'(q.size()), 32'd12);
    for (int i = 0; i < 12; i++) expect_word(i, tbl[i].exp, 10'(i), tbl[i].err);
    if (q.size() >= 2) check_eq("sw_beq_consecutive", 32'(q[1].cyc - q[0].cyc), 32'd1);
    check_eq("sticky_set", 32'(err_sticky), 32'd1);
    do_clear();
    check_eq("sticky_cleared", 32'(err_sticky), 32'd0);
    check_eq("clear2_addr", 32'(out_addr), 32'd0);

    // backpressure: 4 requests offered while the consumer stalls 5 cycles
    q.delete();
    n_acc = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(bp[i]);
      end
    join_none
    tick(5);
    check_eq("bp_accepted_while_stalled", 32'(n_acc), 32'd2);
    check_eq("bp_in_ready_low", 32'(in_ready), 32'd0);
    check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
    check_eq("bp_hold_inst", out_inst, 32'h002081B3);
    check_eq("bp_hold_addr", 32'(out_addr), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 30 && n_acc < 4; k++) tick(1);
    check_eq("bp_all_accepted", 32'(n_acc), 32'd4);
    tick(4);
    check_eq("bp_count", 32'(q.size()), 32'd4);
    for (int i = 0; i < 4; i++) expect_word(i, bp[i].exp, 10'(i), 1'b0);

    // park a word at address 5, then pull async reset with no clock edge
    send(tbl[10]);
    tick(3);
    check_eq("pre_rst_addr2", 32'(out_addr2), 32'd2);
    out_ready = 1'b0;
    send(tbl[7]);
    tick(2);
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    check_eq("pre_rst_addr", 32'(out_addr), 32'd5);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst_addr", 32'(out_addr), 32'd0);
    check_eq("async_rst_inst", out_inst, 32'd0);
    tick(1);
    reset_n = 1'b1;
    out_ready = 1'b1;

    // clear against a simultaneous input and output transfer
    q.delete();
    send(tbl[5]);
    send(tbl[7]);
    tick(3);
    check_eq("pre_clr_sticky", 32'(err_sticky), 32'd1);
    check_eq("pre_clr_addr", 32'(out_addr), 32'd2);
    check_eq("pre_clr_addr2", 32'(out_addr2), 32'd3);
    out_ready = 1'b0;
    send(tbl[0]);
    tick(2);
    check_eq("pre_clr_valid", 32'(out_valid), 32'd1);
    clear = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    in_opcode = tbl[1].op; in_imm = tbl[1].imm; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    #1;
    check_eq("clr_in_ready", 32'(in_ready), 32'd0);
    tick(1);
    clear = 1'b0; in_valid = 1'b0;
    check_eq("clr_valid", 32'(out_valid), 32'd0);
    check_eq("clr_addr", 32'(out_addr), 32'd0);
    check_eq("clr_addr2", 32'(out_addr2), 32'd1);
    check_eq("clr_sticky", 32'(err_sticky), 32'd0);
    tick(3);
    check_eq("clr_no_leftover", 32'(out_valid), 32'd0);
    check_eq("clr_transfers", 32'(q.size()), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
